// File: rtl/switch_pkg.sv
// Shared constants and per-output state encoding for the switch allocator and crossbar.
package switch_pkg;
  localparam int N_PORTS = 4;
  localparam int PORT_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } port_state_e;
endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input ports and the switch allocator.
interface switch_allocator_if;
  import switch_pkg::*;

  // An input holds req_valid with a fixed req_dest until grant rises; the
  // connection lasts until the owner raises req_last or drops req_valid.
  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS*PORT_W-1:0] req_dest;
  logic [N_PORTS-1:0]        req_last;
  logic [N_PORTS-1:0]        grant;
  logic [N_PORTS*PORT_W-1:0] sel;
  logic [N_PORTS-1:0]        out_busy;

  modport master (
    output req_valid, req_dest, req_last,
    input  grant, sel, out_busy
  );

  modport slave (
    input  req_valid, req_dest, req_last,
    output grant, sel, out_busy
  );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, modulo N_PORTS.
module rr_arbiter
  import switch_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]  idx
);
  logic [PORT_W-1:0] probe;

  // Walk offsets from far to near so the nearest request overwrites the rest.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    probe = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      probe = ptr + PORT_W'(k);
      if (req[probe]) begin
        gnt        = '0;
        gnt[probe] = 1'b1;
        idx        = probe;
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// Per-output IDLE/BUSY connection FSMs with round-robin arbitration; all outputs registered.
module switch_allocator
  import switch_pkg::port_state_e, switch_pkg::IDLE, switch_pkg::BUSY;
#(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  switch_allocator_if.slave         bus,
  output port_state_e [N_PORTS-1:0] fsm_state
);
  port_state_e [N_PORTS-1:0]             state_q, state_d;
  logic        [N_PORTS-1:0][PORT_W-1:0] owner_q, owner_d;
  logic        [N_PORTS-1:0][PORT_W-1:0] ptr_q, ptr_d;
  logic        [N_PORTS-1:0]             grant_q, grant_d;
  logic        [N_PORTS-1:0]             busy_q, busy_d;
  logic        [N_PORTS*PORT_W-1:0]      sel_q, sel_d;

  logic [N_PORTS-1:0] cand    [N_PORTS];
  logic [N_PORTS-1:0] arb_gnt [N_PORTS];
  logic [PORT_W-1:0]  arb_idx [N_PORTS];

  // Idle outputs only see ungranted inputs naming them; busy outputs see nothing.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      cand[j] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        cand[j][i] = (state_q[j] == IDLE) && bus.req_valid[i] && !grant_q[i] &&
                     (bus.req_dest[i*PORT_W +: PORT_W] == PORT_W'(j));
      end
    end
  end

  for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
    rr_arbiter u_arb (
      .req (cand[j]),
      .ptr (ptr_q[j]),
      .gnt (arb_gnt[j]),
      .idx (arb_idx[j])
    );
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    for (int j = 0; j < N_PORTS; j++) begin
      case (state_q[j])
        IDLE: begin
          if (|arb_gnt[j]) begin
            state_d[j] = BUSY;
            owner_d[j] = arb_idx[j];
            ptr_d[j]   = arb_idx[j] + PORT_W'(1);
          end
        end
        BUSY: begin
          if (!bus.req_valid[owner_q[j]] || bus.req_last[owner_q[j]]) begin
            state_d[j] = IDLE;
            owner_d[j] = '0;
          end
        end
      endcase
    end

    // Output registers are loaded from the next state so they line up with it.
    grant_d = '0;
    busy_d  = '0;
    sel_d   = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      if (state_d[j] == BUSY) begin
        grant_d[owner_d[j]]         = 1'b1;
        busy_d[j]                   = 1'b1;
        sel_d[j*PORT_W +: PORT_W]   = owner_d[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= {N_PORTS{IDLE}};
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      busy_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.out_busy = busy_q;
  assign bus.sel      = sel_q;
  assign fsm_state    = state_q;
endmodule
